// File: rtl/oc8051_cxrom_reader.sv
// rtl/oc8051_cxrom_reader.sv - sequential cxrom range reader with output FIFO
//
// Walks word_count words of code ROM starting at start_addr, ADDR_STEP bytes
// apart (16-bit wrap), and streams them out through a FIFO_DEPTH-entry buffer
// so ROM fetch keeps going while the consumer briefly stalls.
//
// Optional feature macro: OC8051_CXROM_RDR_CSUM_EN adds the csum output, a
// running 32-bit sum of every word handed to the consumer.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   start, start_addr,     run request (accepted only when idle) with its
//   word_count             first address and word count
//   abort                  cancel the current run, flush the FIFO
//   busy, done             run in progress / one-cycle completion pulse
//   cxrom_addr,            combinational ROM interface (same-cycle data)
//   cxrom_data_in
//   out_valid, out_ready,  head-of-FIFO stream with its source address
//   out_data, out_addr
//   csum                   (macro only) sum of consumed words

module oc8051_cxrom_reader #(
  parameter int ADDR_STEP  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] word_count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [15:0] cxrom_addr,
  input  logic [31:0] cxrom_data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [15:0] out_addr
`ifdef OC8051_CXROM_RDR_CSUM_EN
  ,
  output logic [31:0] csum
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [15:0]   remaining;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [15:0]   fifo_addr [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] occ;

  logic          start_ok;
  logic          abort_ok;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          last_push;

  assign start_ok  = (state == S_IDLE) && start;
  assign abort_ok  = (state != S_IDLE) && abort;
  assign fifo_full = (occ == CW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push      = (state == S_FETCH) && !abort && (!fifo_full || pop);
  assign last_push = push && (remaining == 16'd1);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign out_valid = (occ != '0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_addr  = fifo_addr[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (word_count == 16'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (last_push) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave once the FIFO is empty after this cycle's pop.
        if ((occ == '0) || ((occ == CW'(1)) && pop)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort_ok) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining  <= '0;
      cxrom_addr <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      if (start_ok) begin
        remaining <= word_count;
        // An empty run never fetches, so the ROM address is left alone.
        if (word_count != 16'd0) begin
          cxrom_addr <= start_addr;
        end
      end
      if (push) begin
        fifo_data[wr_ptr] <= cxrom_data_in;
        fifo_addr[wr_ptr] <= cxrom_addr;
        wr_ptr            <= wr_ptr + 1'b1;
        remaining         <= remaining - 16'd1;
        // Keep the last fetched address on the bus after the final word.
        if (!last_push) begin
          cxrom_addr <= cxrom_addr + 16'(ADDR_STEP);
        end
      end
      if (abort_ok) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   occ <= occ + CW'(1);
          2'b01:   occ <= occ - CW'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

`ifdef OC8051_CXROM_RDR_CSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= '0;
    end else if (abort_ok || start_ok) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_oc8051_cxrom_reader.sv
// tb/tb_oc8051_cxrom_reader.sv - self-checking bench for oc8051_cxrom_reader
//
// Drives directed and randomized read runs against a ROM model and checks the
// streamed words, busy/done timing and (with OC8051_CXROM_RDR_CSUM_EN) csum
// against a transaction-level reference model.

module tb_oc8051_cxrom_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] word_count;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_addr;
`ifdef OC8051_CXROM_RDR_CSUM_EN
  logic [31:0] csum;
`endif

  always #5 clk = ~clk;

  oc8051_cxrom_reader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_addr    (start_addr),
    .word_count    (word_count),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .cxrom_addr    (cxrom_addr),
    .cxrom_data_in (cxrom_data_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_addr      (out_addr)
`ifdef OC8051_CXROM_RDR_CSUM_EN
    ,
    .csum          (csum)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ROM model: a*0x01010101 ^ key, with an optional three-word override window.
  logic [31:0] rom_key  = '0;
  logic        ovr_en   = 1'b0;
  logic [15:0] ovr_base = '0;
  logic [31:0] ovr_w [3];

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    logic [15:0] off;
    off = a - ovr_base;
    if (ovr_en && off < 16'd12) begin
      return ovr_w[off[3:2]];
    end
    return ({16'h0000, a} * 32'h01010101) ^ rom_key;
  endfunction

  always @(cxrom_addr, rom_key, ovr_en, ovr_base) cxrom_data_in = rom_word(cxrom_addr);

  // Reference model: expected word stream of the current run plus run status
  // as seen at the next sample point.
  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        exp_q[$];
  bit          act      = 1'b0;
  bit          dn       = 1'b0;
  int          run_n    = 0;
  int          run_pops = 0;
  logic [31:0] csum_m   = '0;

  // One clock: sample/check at the negedge, apply inputs, advance the model
  // to what the next posedge does, then wait for the next negedge.
  task automatic cycle(input bit st, input logic [15:0] sa, input logic [15:0] wc,
                       input bit ab, input bit rdy);
    bit   v;
    bit   act_n;
    bit   dn_n;
    ent_t e;
    check_eq("busy", busy, act);
    check_eq("done", done, dn);
    if (!act || dn) check_eq("valid_when_idle", out_valid, 0);
`ifdef OC8051_CXROM_RDR_CSUM_EN
    check_eq("csum", csum, csum_m);
`endif
    start = st; start_addr = sa; word_count = wc; abort = ab; out_ready = rdy;
    v     = out_valid;
    act_n = act;
    dn_n  = 1'b0;
    if (v && rdy) begin
      check_eq("pop_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("out_addr", out_addr, e.a);
        check_eq("out_data", out_data, e.d);
        run_pops++;
        csum_m += e.d;
      end
    end
    if (dn) begin
      act_n = 1'b0;
      if (ab) csum_m = '0;
    end else if (act && ab) begin
      act_n = 1'b0;
      exp_q.delete();
      csum_m = '0;
    end else if (act) begin
      if (v && rdy && run_pops == run_n) begin
        dn_n = 1'b1;
        check_eq("word_total", run_pops, run_n);
      end
    end else if (st) begin
      act_n    = 1'b1;
      dn_n     = (wc == 16'd0);
      run_n    = int'(wc);
      run_pops = 0;
      csum_m   = '0;
      exp_q.delete();
      for (int i = 0; i < int'(wc); i++) begin
        logic [15:0] a;
        a = sa + 16'(4 * i);
        exp_q.push_back({a, rom_word(a)});
      end
    end
    act = act_n;
    dn  = dn_n;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_idle(input int rdy_pct, input int ab_pct, input int st_pct);
    int g;
    g = 0;
    while (act && g < 400) begin
      cycle($urandom_range(0, 99) < st_pct, 16'($urandom), 16'($urandom_range(0, 9)),
            $urandom_range(0, 99) < ab_pct, $urandom_range(0, 99) < rdy_pct);
      g++;
    end
    check_eq("run_finished", act, 0);
    cycle(0, 16'h0, 16'h0, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_cxrom_addr", cxrom_addr, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_addr", out_addr, 0);
`ifdef OC8051_CXROM_RDR_CSUM_EN
    check_eq("rst_csum", csum, 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // 4 words from 0x0010 with a consumer that is always ready.
    cycle(1, 16'h0010, 16'd4, 0, 1);
    k = 1;
    check_eq("t1_cxrom_addr_n1", cxrom_addr, 16'h0010);
    check_eq("t1_valid_n1", out_valid, 0);
    cycle(0, 16'h0, 16'h0, 0, 1);
    k = 2;
    check_eq("t1_valid_n2", out_valid, 1);
    check_eq("t1_head_n2", out_addr, 16'h0010);
    check_eq("t1_data_n2", out_data, 32'h10101010);
    while (!done && k < 20) begin
      cycle(0, 16'h0, 16'h0, 0, 1);
      k++;
    end
    check_eq("t1_done_cycle", k, 6);
    run_to_idle(100, 0, 0);

    // Empty run.
    cycle(1, 16'h0040, 16'd0, 0, 1);
    check_eq("t2_busy", busy, 1);
    check_eq("t2_done", done, 1);
    check_eq("t2_valid", out_valid, 0);
    cycle(0, 16'h0, 16'h0, 0, 1);
    check_eq("t2_idle", busy, 0);

    // Consumer stall: fetch stops once the FIFO is full.
    cycle(1, 16'h0100, 16'd6, 0, 0);
    repeat (10) cycle(0, 16'h0, 16'h0, 0, 0);
    check_eq("t3_addr_stall", cxrom_addr, 16'h0108);
    check_eq("t3_head_hold", out_addr, 16'h0100);
    check_eq("t3_valid", out_valid, 1);
    run_to_idle(100, 0, 0);
    check_eq("t3_pops", run_pops, 6);

    // Address wrap at the top of the 16-bit space.
    cycle(1, 16'hFFF8, 16'd4, 0, 1);
    run_to_idle(100, 0, 0);
    check_eq("t4_pops", run_pops, 4);

    // Abort after the second pop, then a normal run.
    cycle(1, 16'h0200, 16'd5, 0, 1);
    k = 0;
    while (run_pops < 2 && k < 20) begin
      cycle(0, 16'h0, 16'h0, 0, 1);
      k++;
    end
    cycle(0, 16'h0, 16'h0, 1, 1);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_valid", out_valid, 0);
    check_eq("t5_done", done, 0);
    repeat (3) cycle(0, 16'h0, 16'h0, 0, 1);
    cycle(1, 16'h0220, 16'd3, 0, 1);
    run_to_idle(100, 0, 0);
    check_eq("t5_rerun_pops", run_pops, 3);

    // Abort while idle does nothing; abort together with start lets start win.
    cycle(0, 16'h0, 16'h0, 1, 1);
    check_eq("idle_abort_busy", busy, 0);
    cycle(1, 16'h0400, 16'd2, 1, 1);
    check_eq("start_over_abort", busy, 1);
    run_to_idle(100, 0, 0);

    // Checksum wrap and a start request while busy.
    ovr_w[0] = 32'h00000001; ovr_w[1] = 32'hFFFFFFFF; ovr_w[2] = 32'h00000005;
    ovr_base = 16'h0300;
    ovr_en   = 1'b1;
    cycle(1, 16'h0300, 16'd3, 0, 1);
    cycle(0, 16'h0, 16'h0, 0, 1);
    cycle(1, 16'h0500, 16'd7, 0, 1);
    run_to_idle(100, 0, 0);
    check_eq("t6_pops", run_pops, 3);
`ifdef OC8051_CXROM_RDR_CSUM_EN
    check_eq("t6_csum", csum, 32'h00000005);
`endif
    repeat (2) cycle(0, 16'h0, 16'h0, 0, 1);
    ovr_en = 1'b0;

    // Randomized runs with stalls, aborts and start requests while busy.
    repeat (40) begin
      rom_key = $urandom;
      cycle(1, 16'($urandom), 16'($urandom_range(0, 9)), 0, $urandom_range(0, 1) == 1);
      run_to_idle($urandom_range(30, 100), 3, 10);
      repeat ($urandom_range(0, 2)) cycle(0, 16'h0, 16'h0, $urandom_range(0, 1) == 1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
